// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: per-channel off/on/blink/PWM selection, with a shared
// prescaler, blink phase and PWM counter. All outputs are registered.
module led_pattern_ctrl #(
    parameter int unsigned CH       = 3,
    parameter int unsigned DIV      = 4,
    parameter int unsigned BLINK    = 2,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [2*CH-1:0]       mode,
    input  logic [PWM_BITS-1:0]   duty,
    output logic [CH-1:0]         led,
    output logic                  tick
);

    localparam int unsigned PREW = (DIV   > 1) ? $clog2(DIV)   : 1;
    localparam int unsigned BCW  = (BLINK > 1) ? $clog2(BLINK) : 1;

    localparam logic [PREW-1:0] PRE_MAX = PREW'(DIV - 1);
    localparam logic [BCW-1:0]  BC_MAX  = BCW'(BLINK - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    typedef enum logic {
        PH_DARK = 1'b0,
        PH_LIT  = 1'b1
    } phase_e;

    logic [PREW-1:0]     pre,  pre_nxt;
    logic [BCW-1:0]      bc,   bc_nxt;
    phase_e              ph,   ph_nxt;
    logic [PWM_BITS-1:0] pc,   pc_nxt;
    logic [PWM_BITS-1:0] dsh,  dsh_nxt;
    logic                tick_nxt;
    logic [CH-1:0]       led_nxt;

    logic pre_wrap;
    logic bc_adv;
    logic bc_wrap;
    logic pc_wrap;
    logic pwm_lvl;

    assign pre_wrap = en && (pre == PRE_MAX);
    assign bc_adv   = en && tick;
    assign bc_wrap  = bc_adv && (bc == BC_MAX);
    assign pc_wrap  = en && (pc == '1);
    assign pwm_lvl  = (pc < dsh);

    // Counter next-state; blink wrap and PWM wrap are independent and may coincide.
    always_comb begin
        pre_nxt  = pre;
        bc_nxt   = bc;
        ph_nxt   = ph;
        pc_nxt   = pc;
        dsh_nxt  = dsh;
        tick_nxt = 1'b0;

        if (en) begin
            pre_nxt  = pre_wrap ? '0 : pre + 1'b1;
            tick_nxt = pre_wrap;
            pc_nxt   = pc + 1'b1;
        end

        if (bc_adv) begin
            bc_nxt = bc_wrap ? '0 : bc + 1'b1;
        end

        if (bc_wrap) begin
            ph_nxt = (ph == PH_LIT) ? PH_DARK : PH_LIT;
        end

        if (pc_wrap) begin
            dsh_nxt = duty;
        end
    end

    // LED drive decoded from the present mode and the present (pre-edge) state.
    always_comb begin
        led_nxt = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            case (mode_e'(mode[2*i +: 2]))
                MODE_OFF:   led_nxt[i] = 1'b0;
                MODE_ON:    led_nxt[i] = 1'b1;
                MODE_BLINK: led_nxt[i] = (ph == PH_LIT);
                MODE_PWM:   led_nxt[i] = pwm_lvl;
                default:    led_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre  <= '0;
            bc   <= '0;
            ph   <= PH_DARK;
            pc   <= '0;
            dsh  <= '0;
            tick <= 1'b0;
            led  <= '0;
        end else begin
            pre  <= pre_nxt;
            bc   <= bc_nxt;
            ph   <= ph_nxt;
            pc   <= pc_nxt;
            dsh  <= dsh_nxt;
            tick <= tick_nxt;
            led  <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: an event-count model checked every
// cycle, plus directed literal expectations for the key waveforms.
module tb_led_pattern_ctrl;

    localparam int unsigned CH       = 3;
    localparam int unsigned DIV      = 4;
    localparam int unsigned BLINK    = 2;
    localparam int unsigned PWM_BITS = 4;
    localparam int          PERIOD   = 1 << PWM_BITS;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                en = 1'b0;
    logic [2*CH-1:0]     mode = '0;
    logic [PWM_BITS-1:0] duty = '0;
    logic [CH-1:0]       led;
    logic                tick;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    led_pattern_ctrl #(
        .CH(CH), .DIV(DIV), .BLINK(BLINK), .PWM_BITS(PWM_BITS)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .duty(duty),
        .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: E = enabled edges since reset, T = ticks consumed by the blink counter.
    // Blink phase is (T / BLINK) mod 2, PWM position is E mod 2^PWM_BITS.
    int          m_e = 0;
    int          m_t = 0;
    int          m_dsh = 0;
    logic        m_tick = 1'b0;
    logic [CH-1:0] m_led = '0;

    always @(posedge clk) begin
        logic [CH-1:0] nl;
        int ph, lvl;
        if (!reset) begin
            m_e = 0; m_t = 0; m_dsh = 0; m_tick = 1'b0; m_led = '0;
        end else begin
            ph  = (m_t / BLINK) % 2;
            lvl = ((m_e % PERIOD) < m_dsh) ? 1 : 0;
            for (int c = 0; c < CH; c++) begin
                case (mode[2*c +: 2])
                    2'b00:   nl[c] = 1'b0;
                    2'b01:   nl[c] = 1'b1;
                    2'b10:   nl[c] = ph[0];
                    default: nl[c] = lvl[0];
                endcase
            end
            m_led = nl;
            if (en) begin
                if (m_tick) m_t++;
                m_e++;
                if (m_e % PERIOD == 0) m_dsh = int'(duty);
                m_tick = (m_e % DIV == 0);
            end else begin
                m_tick = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_led", int'(led), int'(m_led));
            check("model_tick", int'(tick), int'(m_tick));
        end
    end

    function automatic int pwm4_exp(input int k);
        if (k <= 16) return 0;
        if (k <= 32) return ((k - 17) < 4)  ? 1 : 0;
        if (k <= 48) return ((k - 33) < 4)  ? 1 : 0;
        if (k <= 64) return ((k - 49) < 12) ? 1 : 0;
        if (k <= 80) return ((k - 65) < 12) ? 1 : 0;
        if (k <= 96) return 0;
        return ((k - 97) < 15) ? 1 : 0;
    endfunction

    initial begin
        // Power-up reset
        repeat (3) @(negedge clk);
        started = 1'b1;
        check("reset_led", int'(led), 0);
        check("reset_tick", int'(tick), 0);

        // All channels on; tick only after edges 4, 8, 12
        en = 1'b1; mode = 6'b010101; reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("on_led", int'(led), 7);
            check("on_tick", int'(tick), (k % 4 == 0) ? 1 : 0);
        end

        // Blink on ch0/ch1, then freeze for 10 cycles
        reset = 1'b0; mode = 6'b001010;
        @(negedge clk);
        check("rst2_led", int'(led), 0);
        check("rst2_tick", int'(tick), 0);
        reset = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("blink_led0", int'(led[0]), (k >= 10 && ((k - 10) / 8) % 2 == 0) ? 1 : 0);
            check("blink_led1", int'(led[1]), (k >= 10 && ((k - 10) / 8) % 2 == 0) ? 1 : 0);
            check("blink_led2", int'(led[2]), 0);
        end
        en = 1'b0;
        for (int k = 31; k <= 40; k++) begin
            @(negedge clk);
            check("freeze_tick", int'(tick), 0);
            check("freeze_led0", int'(led[0]), 1);
        end
        en = 1'b1;
        repeat (24) @(negedge clk);

        // PWM on ch0, ch2 on; duty 4 -> 12 mid-window -> 0 -> 15
        reset = 1'b0; mode = 6'b010011; duty = 4'd4;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 112; k++) begin
            @(negedge clk);
            check("pwm_led0", int'(led[0]), pwm4_exp(k));
            check("pwm_led2", int'(led[2]), 1);
            if (k == 40) duty = 4'd12;
            if (k == 64) duty = 4'd0;
            if (k == 90) duty = 4'd15;
        end
        repeat (5) @(negedge clk);

        // One-edge reset mid-PWM
        reset = 1'b0;
        @(negedge clk);
        check("midrst_led", int'(led), 0);
        check("midrst_tick", int'(tick), 0);
        reset = 1'b1;
        @(negedge clk);
        check("relit_led", int'(led), 4);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
